// File: rtl/hazard_forward_ctrl.sv
// Execute-stage hazard controller: tracks in-flight destinations, stalls on unresolvable RAW,
// flushes on taken branches and registers the EX operand forwarding selects.
module hazard_forward_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             branch_taken_3,
    input  logic             frwd_en,
    output logic [1:0]       frwdControl_1,
    output logic [1:0]       frwdControl_2,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count
);

    // The WB slot and the EX source fields never influence a decision (the register file is
    // write-first and selects are resolved on entry to EX), so only what matters is stored.
    logic             ex_valid_q, ex_we_q, ex_ld_q;
    logic [4:0]       ex_rd_q;
    logic             mem_valid_q, mem_we_q;
    logic [4:0]       mem_rd_q;
    logic [1:0]       frwd_sel_1_d, frwd_sel_2_d;
    logic [CNT_W-1:0] stall_count_d;

    logic use_rs, use_rt;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, raw_hazard;

    function automatic logic is_prod(logic v, logic we, logic [4:0] rd, logic [4:0] r);
        return v && we && (rd == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit, logic ex_ld);
        if (ex_hit && !ex_ld) return 2'b01;
        if (mem_hit)          return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        use_rs     = id_valid & id_uses_rs;
        use_rt     = id_valid & id_uses_rt;
        ex_hit_rs  = use_rs & is_prod(ex_valid_q, ex_we_q, ex_rd_q, id_rs);
        ex_hit_rt  = use_rt & is_prod(ex_valid_q, ex_we_q, ex_rd_q, id_rt);
        mem_hit_rs = use_rs & is_prod(mem_valid_q, mem_we_q, mem_rd_q, id_rs);
        mem_hit_rt = use_rt & is_prod(mem_valid_q, mem_we_q, mem_rd_q, id_rt);
        load_use   = ex_ld_q & (ex_hit_rs | ex_hit_rt);
        raw_hazard = ex_hit_rs | ex_hit_rt | mem_hit_rs | mem_hit_rt;

        // A taken branch squashes the ID instruction, voiding its hazard.
        flush  = branch_taken_3;
        stall  = ~flush & (frwd_en ? load_use : raw_hazard);
        bubble = stall | flush;
    end

    always_comb begin
        frwd_sel_1_d = 2'b00;
        frwd_sel_2_d = 2'b00;
        if (frwd_en && !bubble) begin
            frwd_sel_1_d = fwd_sel(ex_hit_rs, mem_hit_rs, ex_ld_q);
            frwd_sel_2_d = fwd_sel(ex_hit_rt, mem_hit_rt, ex_ld_q);
        end
        stall_count_d = stall_count;
        if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_we_q       <= 1'b0;
            ex_ld_q       <= 1'b0;
            ex_rd_q       <= 5'd0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_rd_q      <= 5'd0;
            frwdControl_1 <= 2'b00;
            frwdControl_2 <= 2'b00;
            stall_count   <= '0;
        end else begin
            mem_valid_q   <= ex_valid_q;
            mem_we_q      <= ex_we_q;
            mem_rd_q      <= ex_rd_q;
            ex_valid_q    <= id_valid & ~bubble;
            ex_we_q       <= id_regWrite;
            ex_ld_q       <= id_memRead;
            ex_rd_q       <= id_rd;
            frwdControl_1 <= frwd_sel_1_d;
            frwdControl_2 <= frwd_sel_2_d;
            stall_count   <= stall_count_d;
        end
    end

endmodule
